fir_out_decimator: RTL

//   Downstream stage of the FIR filter. Consumes filtered samples over a 4-phase req/ack handshake,

---
 rtl/fir_out_decimator.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fir_out_decimator.sv
// Output stage of the FIR filter: 4-phase req/ack input, decimate-by-DECIM, FIFO buffer, 4-phase req/ack output.
// Optional boxcar averaging of each DECIM-sample group is enabled by defining DECIM_ACCUM_EN.
module fir_out_decimator #(
    parameter int DWIDTH     = 16,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_req,
    output logic                          in_ack,
    input  logic [DWIDTH-1:0]             in_data,
    output logic                          out_req,
    input  logic                          out_ack,
    output logic [DWIDTH-1:0]             out_data,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PW = $clog2(DECIM);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
    localparam logic [LW-1:0] DEPTH_L    = LW'(FIFO_DEPTH);

    typedef enum logic {
        IN_IDLE,
        IN_ACK
    } in_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_REQ,
        OUT_WAIT
    } out_state_t;

    in_state_t         in_state_q, in_state_d;
    out_state_t        out_state_q, out_state_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DWIDTH-1:0] out_data_q, out_data_d;
    logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];

    logic              keep;
    logic              full;
    logic              push;
    logic              pop;
    logic [DWIDTH-1:0] push_data;

    assign keep = (phase_q == PHASE_LAST);
    assign full = (level_q >= DEPTH_L);

`ifdef DECIM_ACCUM_EN
    localparam int ACCW = DWIDTH + PW;

    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [ACCW-1:0] acc_sum;

    assign acc_sum   = acc_q + {{PW{in_data[DWIDTH-1]}}, in_data};
    // Dropping the low PW bits is the floor (arithmetic) divide by DECIM.
    assign push_data = acc_sum[ACCW-1:PW];
`else
    assign push_data = in_data;
`endif

    // Input handshake: accept, advance phase, push on the keep sample.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        in_state_d = in_state_q;
        phase_d    = phase_q;
        push       = 1'b0;
`ifdef DECIM_ACCUM_EN
        acc_d      = acc_q;
`endif
        case (in_state_q)
            IN_IDLE: begin
                if (in_req && (!keep || !full)) begin
                    in_state_d = IN_ACK;
                    phase_d    = phase_q + 1'b1;
                    push       = keep;
`ifdef DECIM_ACCUM_EN
                    acc_d      = keep ? '0 : acc_sum;
`endif
                end
            end
            IN_ACK: begin
                if (!in_req) begin
                    in_state_d = IN_IDLE;
                end
            end
        endcase
    end

    // Output handshake: head stays in the FIFO until the sink acknowledges it.
    always_comb begin
        out_state_d = out_state_q;
        out_data_d  = out_data_q;
        pop         = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if ((level_q != '0) && !out_ack) begin
                    out_state_d = OUT_REQ;
                    out_data_d  = mem_q[rd_ptr_q];
                end
            end
            OUT_REQ: begin
                if (out_ack) begin
                    out_state_d = OUT_WAIT;
                    pop         = 1'b1;
                end
            end
            OUT_WAIT: begin
                if (!out_ack) begin
                    out_state_d = OUT_IDLE;
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_state_q  <= IN_IDLE;
            out_state_q <= OUT_IDLE;
            phase_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_data_q  <= '0;
`ifdef DECIM_ACCUM_EN
            acc_q       <= '0;
`endif
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            phase_q     <= phase_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_data_q  <= out_data_d;
`ifdef DECIM_ACCUM_EN
            acc_q       <= acc_d;
`endif
        end
    end

    // NOTE: storage array is not reset; resetting the pointers and level discards its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign in_ack   = (in_state_q == IN_ACK);
    assign out_req  = (out_state_q == OUT_REQ);
    assign out_data = out_data_q;
    assign level    = level_q;

endmodule
